// File: rtl/uart_pkg.sv
// Shared definitions for the UART subsystem: transmit FSM states, parity
// selector constants and the frame-length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Total CLK cycles of one frame; a zero period behaves as one cycle per bit.
    function automatic int unsigned frame_cycles(int unsigned data_width,
                                                 logic        parity_en,
                                                 logic        two_stop,
                                                 int unsigned period);
        int unsigned p;
        int unsigned bits;
        p    = (period == 0) ? 1 : period;
        bits = 2 + data_width + (parity_en ? 1 : 0) + (two_stop ? 1 : 0);
        return bits * p;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Write-side handshake of the buffered UART transmitter: data, strobe, ready.
interface uart_tx_buffered_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] TX_IN_P;
    logic                  TX_IN_V;
    logic                  TX_IN_RDY;

    modport master (output TX_IN_P, output TX_IN_V, input TX_IN_RDY);
    modport slave  (input TX_IN_P, input TX_IN_V, output TX_IN_RDY);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; shared by the UART transmit and
// receive paths.
module uart_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push;
    logic                  pop;

    // A write while full is refused even when a read frees a slot on the same edge.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter with runtime bit period, optional parity and
// one or two stop bits; frames stream back-to-back while the FIFO holds data.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int PERIOD_W   = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    uart_tx_buffered_if.slave             tx_in,
    input  logic [PERIOD_W-1:0]           Bit_Period,
    input  logic                          parity_enable,
    input  logic                          parity_type,
    input  logic                          stop_two,
    output logic                          TX_OUT_S,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int IW = $clog2(DATA_WIDTH);

    tx_state_t             state;
    logic [PERIOD_W-1:0]   bit_timer;
    logic [PERIOD_W-1:0]   period_last;
    logic [IW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] head;
    logic                  parity_bit;
    logic                  parity_en_l;
    logic                  stop_two_l;
    logic                  stop_idx;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  bit_end;
    logic                  last_stop_end;
    logic                  pop;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (tx_in.TX_IN_V),
        .wr_data (tx_in.TX_IN_P),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign tx_in.TX_IN_RDY = !fifo_full;

    // The head entry is popped exactly on the edge that starts a new frame.
    assign bit_end       = (bit_timer == period_last);
    assign last_stop_end = (state == STOP) && bit_end && (!stop_two_l || stop_idx);
    assign pop           = !fifo_empty && ((state == IDLE) || last_stop_end);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            TX_OUT_S    <= 1'b1;
            busy        <= 1'b0;
            overflow    <= 1'b0;
            bit_timer   <= '0;
            period_last <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            parity_bit  <= 1'b0;
            parity_en_l <= 1'b0;
            stop_two_l  <= 1'b0;
            stop_idx    <= 1'b0;
        end else begin
            overflow <= tx_in.TX_IN_V && fifo_full;
            // Configuration is captured here so mid-frame changes only affect later frames.
            if (pop) begin
                state       <= START;
                TX_OUT_S    <= 1'b0;
                busy        <= 1'b1;
                bit_timer   <= '0;
                bit_idx     <= '0;
                stop_idx    <= 1'b0;
                shreg       <= head;
                parity_bit  <= (^head) ^ (parity_type == PAR_ODD);
                parity_en_l <= parity_enable;
                stop_two_l  <= stop_two;
                period_last <= (Bit_Period == '0) ? '0 : Bit_Period - PERIOD_W'(1);
            end else begin
                case (state)
                    IDLE: begin
                        TX_OUT_S <= 1'b1;
                        busy     <= 1'b0;
                    end
                    START: begin
                        if (bit_end) begin
                            bit_timer <= '0;
                            state     <= DATA;
                            TX_OUT_S  <= shreg[0];
                        end else begin
                            bit_timer <= bit_timer + 1'b1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            bit_timer <= '0;
                            if (bit_idx == IW'(DATA_WIDTH - 1)) begin
                                bit_idx <= '0;
                                if (parity_en_l) begin
                                    state    <= PARITY;
                                    TX_OUT_S <= parity_bit;
                                end else begin
                                    state    <= STOP;
                                    TX_OUT_S <= 1'b1;
                                end
                            end else begin
                                bit_idx  <= bit_idx + 1'b1;
                                shreg    <= shreg >> 1;
                                TX_OUT_S <= shreg[1];
                            end
                        end else begin
                            bit_timer <= bit_timer + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            bit_timer <= '0;
                            state     <= STOP;
                            TX_OUT_S  <= 1'b1;
                        end else begin
                            bit_timer <= bit_timer + 1'b1;
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            bit_timer <= '0;
                            if (last_stop_end) begin
                                state    <= IDLE;
                                TX_OUT_S <= 1'b1;
                                busy     <= 1'b0;
                            end else begin
                                stop_idx <= 1'b1;
                            end
                        end else begin
                            bit_timer <= bit_timer + 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        TX_OUT_S <= 1'b1;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
